// File: rtl/lif_pkg.sv
// Shared types, default parameters and saturating helpers for the multi-channel LIF neuron.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef enum logic {
    LEAK_LIN   = 1'b0,
    LEAK_SHIFT = 1'b1
  } leak_mode_t;

  localparam int unsigned DEF_N_CH     = 4;
  localparam int unsigned DEF_IN_W     = 3;
  localparam int unsigned DEF_WT_W     = 4;
  localparam int unsigned DEF_V_W      = 10;
  localparam int unsigned DEF_REFR_W   = 3;
  localparam int unsigned DEF_THR_UP   = 4;
  localparam int unsigned DEF_THR_DN   = 1;
  localparam int unsigned DEF_DEP_STEP = 2;

  // Unsigned add clamped to max_v; callers cast operands to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

  // Unsigned subtract floored at zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // Clamp into [lo, hi]; hi wins when lo > hi.
  function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic [31:0] t;
    t = (x < lo) ? lo : x;
    return (t > hi) ? hi : t;
  endfunction

endpackage

// File: rtl/lif_leak_unit.sv
// Combinational membrane leak: linear subtract or proportional shift.
module lif_leak_unit
  import lif_pkg::*;
#(
  parameter int unsigned V_W = DEF_V_W
) (
  input  logic [V_W-1:0] i_v,
  input  leak_mode_t     i_leak_mode,
  input  logic [3:0]     i_leak_val,
  output logic [V_W-1:0] o_v_c
);

  logic [V_W-1:0] w_shifted;

  assign w_shifted = i_v >> i_leak_val;

  // Select leak flavour; a zero shift count means no leak at all.
  always_comb begin
    o_v_c = i_v;
    if (i_leak_mode == LEAK_SHIFT) begin
      if (i_leak_val != 4'd0) begin
        o_v_c = i_v - w_shifted;
      end
    end else begin
      o_v_c = V_W'(sat_sub(32'(i_v), 32'(i_leak_val)));
    end
  end

endmodule

// File: rtl/lif_neuron_mc.sv
// Multi-channel LIF neuron: time-multiplexed MAC, leak, refractory, adaptive threshold, depression.
module lif_neuron_mc
  import lif_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned WT_W     = DEF_WT_W,
  parameter int unsigned V_W      = DEF_V_W,
  parameter int unsigned REFR_W   = DEF_REFR_W,
  parameter int unsigned THR_UP   = DEF_THR_UP,
  parameter int unsigned THR_DN   = DEF_THR_DN,
  parameter int unsigned DEP_STEP = DEF_DEP_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [N_CH*IN_W-1:0]   chan_in,
  input  logic [N_CH*WT_W-1:0]   weights,
  input  logic                   leak_mode,
  input  logic [3:0]             leak_val,
  input  logic [REFR_W-1:0]      refr_period,
  input  logic [V_W-1:0]         threshold_min,
  input  logic [V_W-1:0]         threshold_max,
  output logic                   spike_out,
  output logic                   out_valid,
  output logic [V_W-1:0]         v_mem_out,
  output logic [V_W-1:0]         threshold_out
);

  localparam int unsigned IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned ACC_W   = V_W + 1;
  localparam int unsigned PROD_W  = IN_W + WT_W;
  localparam logic [31:0] ACC_MAX = (32'd1 << ACC_W) - 32'd1;
  localparam logic [31:0] V_MAX   = (32'd1 << V_W) - 32'd1;
  localparam logic [31:0] DEP_MAX = (32'd1 << WT_W) - 32'd1;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [ACC_W-1:0]      r_acc;
  logic [V_W-1:0]        r_v;
  logic [V_W-1:0]        r_thr;
  logic [V_W-1:0]        r_thr_out;
  logic [REFR_W-1:0]     r_refr;
  logic [WT_W-1:0]       r_dep [N_CH];
  logic [N_CH*IN_W-1:0]  r_chan;
  logic [N_CH*WT_W-1:0]  r_wt;
  logic                  r_alive;
  logic                  r_spike;
  logic                  r_out_valid;

  logic [IN_W-1:0]       w_act;
  logic [WT_W-1:0]       w_wt;
  logic [WT_W-1:0]       w_effw;
  logic [PROD_W-1:0]     w_prod;
  logic [ACC_W-1:0]      w_acc_sum;
  logic                  w_last;
  logic [V_W-1:0]        w_leak;
  logic [V_W-1:0]        w_v_sum;
  logic [V_W-1:0]        w_thr_eff;
  logic                  w_refr_active;
  logic                  w_fire;
  logic [V_W-1:0]        w_thr_up;
  logic [V_W-1:0]        w_thr_dn;
  logic [V_W-1:0]        w_thr_next;
  logic [V_W-1:0]        w_v_next;

  // Current channel operands and depressed weight feeding the shared MAC.
  assign w_act     = r_chan[32'(r_idx)*IN_W +: IN_W];
  assign w_wt      = r_wt[32'(r_idx)*WT_W +: WT_W];
  assign w_effw    = WT_W'(sat_sub(32'(w_wt), 32'(r_dep[r_idx])));
  assign w_prod    = PROD_W'(w_act) * PROD_W'(w_effw);
  assign w_acc_sum = ACC_W'(sat_add(32'(r_acc), 32'(w_prod), ACC_MAX));
  assign w_last    = (r_idx == IDX_W'(N_CH - 1));

  lif_leak_unit #(
    .V_W (V_W)
  ) u_leak (
    .i_v         (r_v),
    .i_leak_mode (leak_mode_t'(leak_mode)),
    .i_leak_val  (leak_val),
    .o_v_c       (w_leak)
  );

  // Membrane update and threshold adaptation decisions for the UPDATE cycle.
  assign w_v_sum       = V_W'(sat_add(32'(w_leak), 32'(r_acc), V_MAX));
  assign w_thr_eff     = V_W'(clamp(32'(r_thr), 32'(threshold_min), 32'(threshold_max)));
  assign w_refr_active = (r_refr != '0);
  assign w_fire        = !w_refr_active && (w_v_sum >= w_thr_eff);
  assign w_thr_up      = V_W'(sat_add(32'(w_thr_eff), THR_UP, 32'(threshold_max)));
  assign w_thr_dn      = V_W'(clamp(sat_sub(32'(w_thr_eff), THR_DN), 32'(threshold_min),
                                    V_MAX));
  assign w_thr_next    = w_fire ? w_thr_up : w_thr_dn;
  assign w_v_next      = w_refr_active ? w_leak : (w_fire ? '0 : w_v_sum);

  assign step_ready    = (r_state == IDLE) && enable && r_alive;
  assign spike_out     = r_spike;
  assign out_valid     = r_out_valid;
  assign v_mem_out     = r_v;
  assign threshold_out = r_thr_out;

  // Control FSM, datapath state and registered outputs; everything freezes when enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_v         <= '0;
      r_thr       <= '0;
      r_thr_out   <= '0;
      r_refr      <= '0;
      r_chan      <= '0;
      r_wt        <= '0;
      r_alive     <= 1'b0;
      r_spike     <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_dep[i] <= '0;
      end
    end else begin
      r_alive <= 1'b1;
      if (enable) begin
        r_spike     <= 1'b0;
        r_out_valid <= 1'b0;
        case (r_state)
          IDLE: begin
            if (step_valid && r_alive) begin
              r_chan  <= chan_in;
              r_wt    <= weights;
              r_acc   <= '0;
              r_idx   <= '0;
              r_state <= ACCUM;
            end
          end
          ACCUM: begin
            r_acc <= w_acc_sum;
            if (w_last) begin
              r_state <= UPDATE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          UPDATE: begin
            r_v         <= w_v_next;
            r_thr       <= w_thr_next;
            r_thr_out   <= V_W'(clamp(32'(w_thr_next), 32'(threshold_min),
                                      32'(threshold_max)));
            r_spike     <= w_fire;
            r_out_valid <= 1'b1;
            if (w_fire) begin
              r_refr <= refr_period;
            end else if (w_refr_active) begin
              r_refr <= r_refr - REFR_W'(1);
            end
            for (int i = 0; i < N_CH; i++) begin
              if (w_fire) begin
                r_dep[i] <= WT_W'(sat_add(32'(r_dep[i]), DEP_STEP, DEP_MAX));
              end else if (r_dep[i] != '0) begin
                r_dep[i] <= r_dep[i] - WT_W'(1);
              end
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_mc.sv
// Directed, table-driven bench for lif_neuron_mc with hand-computed expectations.
module tb_lif_neuron_mc;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned IN_W   = 3;
  localparam int unsigned WT_W   = 4;
  localparam int unsigned V_W    = 10;
  localparam int unsigned REFR_W = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b1;
  logic                 step_valid = 1'b0;
  logic                 step_ready;
  logic [N_CH*IN_W-1:0] chan_in = '0;
  logic [N_CH*WT_W-1:0] weights = '0;
  logic                 leak_mode = 1'b0;
  logic [3:0]           leak_val = '0;
  logic [REFR_W-1:0]    refr_period = '0;
  logic [V_W-1:0]       threshold_min = '0;
  logic [V_W-1:0]       threshold_max = '0;
  logic                 spike_out;
  logic                 out_valid;
  logic [V_W-1:0]       v_mem_out;
  logic [V_W-1:0]       threshold_out;

  int n_checks = 0;
  int n_fail   = 0;

  lif_neuron_mc dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .step_valid    (step_valid),
    .step_ready    (step_ready),
    .chan_in       (chan_in),
    .weights       (weights),
    .leak_mode     (leak_mode),
    .leak_val      (leak_val),
    .refr_period   (refr_period),
    .threshold_min (threshold_min),
    .threshold_max (threshold_max),
    .spike_out     (spike_out),
    .out_valid     (out_valid),
    .v_mem_out     (v_mem_out),
    .threshold_out (threshold_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [11:0] chan;
    logic [15:0] wts;
    logic        lm;
    logic [3:0]  lv;
    logic [2:0]  refr;
    logic [9:0]  tmin;
    logic [9:0]  tmax;
    logic        e_spk;
    logic [9:0]  e_v;
    logic [9:0]  e_thr;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  function automatic vec_t mk(input logic rst, input logic [11:0] chan, input logic [15:0] wts,
                              input logic lm, input logic [3:0] lv, input logic [2:0] refr,
                              input logic [9:0] tmin, input logic [9:0] tmax,
                              input logic e_spk, input logic [9:0] e_v, input logic [9:0] e_thr);
    vec_t r;
    r.rst = rst; r.chan = chan; r.wts = wts; r.lm = lm; r.lv = lv; r.refr = refr;
    r.tmin = tmin; r.tmax = tmax; r.e_spk = e_spk; r.e_v = e_v; r.e_thr = e_thr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold reset for two cycles, check the reset state, release and check readiness.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; step_valid = 1'b0; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset step_ready", 32'(step_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset spike_out", 32'(spike_out), 0);
    chk("reset v_mem_out", 32'(v_mem_out), 0);
    chk("reset threshold_out", 32'(threshold_out), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("step_ready after reset", 32'(step_ready), 1);
  endtask

  // Handshake one timestep and wait (bounded) for out_valid; optional enable stall.
  task automatic run_step(input string tag, input int stall_at, input int stall_len,
                          output int lat, output int spk, output int v, output int thr);
    chk($sformatf("%s step_ready", tag), 32'(step_ready), 1);
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    lat = -1; spk = -1; v = -1; thr = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == stall_at) enable = 1'b0;
      if (n == stall_at + stall_len) enable = 1'b1;
      if (out_valid === 1'b1) begin
        lat = n; spk = int'(spike_out); v = int'(v_mem_out); thr = int'(threshold_out);
        break;
      end
      @(negedge clk);
    end
    enable = 1'b1;
    @(negedge clk);
    chk($sformatf("%s out_valid pulse width", tag), 32'(out_valid), 0);
    chk($sformatf("%s spike pulse width", tag), 32'(spike_out), 0);
  endtask

  task automatic apply(input vec_t t);
    chan_in = t.chan; weights = t.wts; leak_mode = t.lm; leak_val = t.lv;
    refr_period = t.refr; threshold_min = t.tmin; threshold_max = t.tmax;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, spk, v, thr;
    bit saw_valid;

    // Basic spike (refr 0)
    tv[0]  = mk(1, 12'o3333, 16'h2222, 0, 0, 0,   20,   60, 1,   0,   24);
    // Refractory and depression recovery
    tv[1]  = mk(1, 12'o3333, 16'h2222, 0, 0, 2,   20,   60, 1,   0,   24);
    tv[2]  = mk(0, 12'o3333, 16'h2222, 0, 0, 2,   20,   60, 0,   0,   23);
    tv[3]  = mk(0, 12'o3333, 16'h2222, 0, 0, 2,   20,   60, 0,   0,   22);
    tv[4]  = mk(0, 12'o3333, 16'h2222, 0, 0, 2,   20,   60, 1,   0,   26);
    // Shift leak
    tv[5]  = mk(1, 12'o0005, 16'h000A, 1, 1, 0,  200,  300, 0,  50,  200);
    tv[6]  = mk(0, 12'o0005, 16'h000A, 1, 1, 0,  200,  300, 0,  75,  200);
    tv[7]  = mk(0, 12'o0005, 16'h000A, 1, 1, 0,  200,  300, 0,  88,  200);
    // Saturation of membrane at 2^V_W-1
    tv[8]  = mk(1, 12'o7777, 16'hFFFF, 0, 0, 0, 1023, 1023, 0, 420, 1023);
    tv[9]  = mk(0, 12'o7777, 16'hFFFF, 0, 0, 0, 1023, 1023, 0, 840, 1023);
    tv[10] = mk(0, 12'o7777, 16'hFFFF, 0, 0, 0, 1023, 1023, 1,   0, 1023);
    // threshold_min > threshold_max: max wins
    tv[11] = mk(1, 12'o3333, 16'h2222, 0, 0, 0,   50,   30, 0,  24,   30);
    tv[12] = mk(0, 12'o3333, 16'h2222, 0, 0, 0,   50,   30, 1,   0,   30);
    // Linear leak, floored at zero on the first step
    tv[13] = mk(1, 12'o3333, 16'h2222, 0, 5, 0,  100,  200, 0,  24,  100);
    tv[14] = mk(0, 12'o3333, 16'h2222, 0, 5, 0,  100,  200, 0,  43,  100);

    reset = 1'b0;
    for (int k = 0; k < NV; k++) begin
      if (tv[k].rst) do_reset();
      apply(tv[k]);
      run_step($sformatf("vec%0d", k), 0, 0, lat, spk, v, thr);
      chk($sformatf("vec%0d latency", k), 32'(lat), N_CH + 2);
      chk($sformatf("vec%0d spike_out", k), 32'(spk), 32'(tv[k].e_spk));
      chk($sformatf("vec%0d v_mem_out", k), 32'(v), 32'(tv[k].e_v));
      chk($sformatf("vec%0d threshold_out", k), 32'(thr), 32'(tv[k].e_thr));
    end

    // Async reset in the middle of ACCUM aborts the step.
    do_reset();
    apply(tv[5]);
    run_step("pre-abort", 0, 0, lat, spk, v, thr);
    chk("pre-abort v_mem_out", 32'(v), 50);
    step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort step_ready", 32'(step_ready), 0);
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort v_mem_out", 32'(v_mem_out), 0);
    chk("abort threshold_out", 32'(threshold_out), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort step_ready after release", 32'(step_ready), 1);
    saw_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid === 1'b1) saw_valid = 1'b1;
      @(negedge clk);
    end
    chk("abort stale out_valid", 32'(saw_valid), 0);
    chk("abort v_mem_out after release", 32'(v_mem_out), 0);

    // Enable stall for three cycles during ACCUM.
    do_reset();
    apply(tv[0]);
    run_step("stall", 2, 3, lat, spk, v, thr);
    chk("stall latency", 32'(lat), N_CH + 2 + 3);
    chk("stall spike_out", 32'(spk), 1);
    chk("stall v_mem_out", 32'(v), 0);
    chk("stall threshold_out", 32'(thr), 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_mc.md
Name: lif_neuron_mc

Overview:
Multi-channel, parametrised successor to the 2-input LIF neuron. Accepts one timestep of N_CH synaptic inputs per valid/ready handshake. It integrates them time-multiplexed, one channel per cycle, through a shared multiply-accumulate, then performs a single membrane update with:
- selectable leak,
- refractory period,
- adaptive clamped threshold,
- per-channel short-term depression.

It sits between the parameter loader / input encoder and the spike router.

Parameters:
N_CH, 4, number of synaptic channels (>=1)
IN_W, 3, input activation width per channel
WT_W, 4, weight width per channel
V_W, 10, membrane potential and threshold width
REFR_W, 3, refractory counter width
THR_UP, 4, threshold increment per spike
THR_DN, 1, threshold decrement per non-spike update
DEP_STEP, 2, depression added per spike (per channel, saturating at 2^WT_W-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
enable  in  1  global run; when 0 the FSM and all state freeze
step_valid  in  1  timestep inputs present
step_ready  out  1  block can accept a timestep
chan_in  in  N_CH*IN_W  packed activations, channel 0 in LSBs
weights  in  N_CH*WT_W  packed weights, channel 0 in LSBs
leak_mode  in  1  0 = linear subtract, 1 = proportional shift
leak_val  in  4  leak amount (linear) or shift count (shift mode)
refr_period  in  REFR_W  refractory length in timesteps
threshold_min  in  V_W  lower threshold clamp
threshold_max  in  V_W  upper threshold clamp (wins if min > max)
spike_out  out  1  one-cycle spike pulse, qualified by out_valid
out_valid  out  1  one-cycle pulse: update result available
v_mem_out  out  V_W  membrane potential after last update
threshold_out  out  V_W  effective threshold

Behaviour:
- Reset: all outputs 0 except step_ready; FSM=IDLE; v=0; thr_reg=0; refr_cnt=0; depress[*]=0; acc=0. step_ready=0 while reset is asserted, and 1 in the first cycle after release if enable=1.
- Effective threshold: thr_eff = min(max(thr_reg, threshold_min), threshold_max). It is used for the comparison and drives threshold_out.
- FSM states: IDLE, ACCUM, UPDATE.
- step_ready = (state==IDLE) && enable.
- IDLE: on step_valid && step_ready, register chan_in and weights, clear acc, set idx=0, go to ACCUM.
- ACCUM: each cycle acc += chan[idx] * eff_w[idx], where eff_w = weight - depress, floored at 0.
  - acc is V_W+1 bits, saturating at 2^(V_W+1)-1.
  - After idx == N_CH-1, go to UPDATE. ACCUM lasts exactly N_CH cycles.
- Leak function L(v):
  - linear: v - leak_val, floored at 0.
  - shift: v - (v >> leak_val); leak_val = 0 means no leak.
- UPDATE (one cycle, then IDLE):
  - If refr_cnt != 0: refr_cnt--, v = L(v), acc discarded, no spike.
  - Else v_next = min(L(v) + acc, 2^V_W - 1).
    - If v_next >= thr_eff: spike; v = 0; refr_cnt = refr_period; thr_reg = min(thr_eff + THR_UP, threshold_max); depress[i] = sat(depress[i] + DEP_STEP).
    - Else: v = v_next.
  - On every non-spike UPDATE (refractory or not): thr_reg = max(thr_eff - THR_DN, threshold_min); each nonzero depress[i] decrements by 1.
- Outputs are registered at the end of UPDATE. spike_out, out_valid, v_mem_out and threshold_out are valid in the next cycle, while the FSM is in IDLE.
  - spike_out and out_valid are single-cycle pulses.
  - v_mem_out and threshold_out hold their value until the next update.
- Latency: handshake in cycle T, out_valid in cycle T+N_CH+2. Back-to-back throughput is one timestep per N_CH+2 cycles.
- Enable low in any state: state, idx, acc, v, counters and outputs hold. A pending out_valid/spike pulse is deferred until enable returns.
- refr_period = 0: no refractory period.
- Asynchronous reset mid-ACCUM/UPDATE: aborts the step; no out_valid is produced.

Decomposition:
- Package lif_pkg:
  - state enum (IDLE/ACCUM/UPDATE) and leak_mode enum (LEAK_LIN/LEAK_SHIFT);
  - saturating add/sub functions;
  - default parameter constants.
- Sub-module lif_leak_unit: combinational L(v); parameter V_W; inputs v, leak_mode, leak_val.

Test Plan:
Common setup: defaults N_CH=4, IN_W=3, WT_W=4, V_W=10.
1. Basic spike and latency. Stimulus: threshold_min=20, threshold_max=60, leak linear with leak_val=0, refr_period=0, all chan=3, all weights=2, handshake at T. Response: out_valid at T+6, spike_out=1, v_mem_out=0, threshold_out=24.
2. Refractory and depression recovery. Stimulus: refr_period=2, same stimulus repeated. Response:
   - steps 2-3: no spike, v=0, threshold_out 23 then 22;
   - step 4: depression has recovered to 0, acc=24, spike, threshold_out=26.
3. Shift leak. Stimulus: threshold_min=200, threshold_max=300, leak_mode=1, leak_val=1, chan0=5, w0=10, other channels 0. Response: v_mem_out 50, 75, 88 over three steps; no spike.
4. Saturation. Stimulus: all chan=7, all weights=15, threshold_min=threshold_max=1023, leak_val=0. Response: v_mem_out 420, then 840; step 3 saturates to 1023 and spikes.
5. Async reset mid-ACCUM. Stimulus: assert reset at T+2 with no clock edge. Response: outputs 0 and step_ready=0 immediately; after release, step_ready=1, no stale out_valid, v_mem_out=0.
6. Enable stall. Stimulus: enable=0 for 3 cycles during ACCUM of test 1. Response: out_valid at T+9, identical results.
